// File: rtl/t9990_palette_port_pkg.sv
// Shared palette-port definitions for the T9990 register block: selector codes,
// initiator FSM states and the palette pointer advance rule.
// Optional build macro T9990_PALETTE_PREFETCH_EN adds the PF_REQ state.
package t9990_palette_port_pkg;

    localparam int unsigned ENTRY_W = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned PTR_W   = ENTRY_W + SEL_W;
    localparam int unsigned DATA_W  = 6;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [SEL_W-1:0] PLTP_R = 2'd0;
    localparam logic [SEL_W-1:0] PLTP_G = 2'd1;
    localparam logic [SEL_W-1:0] PLTP_B = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ
`ifdef T9990_PALETTE_PREFETCH_EN
        ,
        PF_REQ
`endif
    } pal_state_e;

    // R -> G -> B -> next entry R; selector 3 also moves on to the next entry.
    function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] p);
        logic [ENTRY_W-1:0] entry;
        logic [SEL_W-1:0]   sel;
        entry = p[PTR_W-1:SEL_W];
        sel   = p[SEL_W-1:0];
        if (sel == PLTP_R || sel == PLTP_G) begin
            return {entry, sel + 2'd1};
        end
        return {entry + 6'd1, PLTP_R};
    endfunction

endpackage

// File: rtl/t9990_palette_ptr.sv
// Palette pointer register (entry + selector) with R#14 load and auto-advance.
module t9990_palette_ptr
    import t9990_palette_port_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             load,
    input  logic [PTR_W-1:0] load_data,
    input  logic             adv,
    output logic [PTR_W-1:0] ptr,
    output logic [7:0]       PLTP_OUT
);

    // Load has priority over the advance of a completing access.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_data;
        end else if (adv) begin
            ptr <= ptr_advance(ptr);
        end
    end

    assign PLTP_OUT = ptr;

endmodule

// File: rtl/t9990_palette_port.sv
// CPU-side palette initiator: turns P#1 reads/writes and R#14 loads into
// W_/R_ strobe transactions toward the palette responder.
// Optional build macro T9990_PALETTE_PREFETCH_EN enables read prefetch.
module t9990_palette_port
    import t9990_palette_port_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_n,
    input  logic               P1_WR,
    input  logic               P1_RD,
    input  logic [BYTE_W-1:0]  P1_WDATA,
    output logic [BYTE_W-1:0]  P1_RDATA,
    output logic               BUSY,
    input  logic               PLTP_WE,
    input  logic [BYTE_W-1:0]  PLTP_WDATA,
    output logic [BYTE_W-1:0]  PLTP_OUT,
    input  logic               AIH,
    output logic               W_STROBE,
    output logic [ENTRY_W-1:0] W_ADDR,
    output logic [SEL_W-1:0]   W_PTR,
    output logic [DATA_W-1:0]  W_DATA,
    input  logic               W_ACK,
    output logic               R_STROBE,
    output logic [ENTRY_W-1:0] R_ADDR,
    output logic [SEL_W-1:0]   R_PTR,
    input  logic [DATA_W-1:0]  R_DATA,
    input  logic               R_ACK
);

    pal_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               w_strobe_q, w_strobe_d;
    logic [ENTRY_W-1:0] w_addr_q, w_addr_d;
    logic [SEL_W-1:0]   w_ptr_q, w_ptr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic               r_strobe_q, r_strobe_d;
    logic [ENTRY_W-1:0] r_addr_q, r_addr_d;
    logic [SEL_W-1:0]   r_ptr_q, r_ptr_d;
    logic [BYTE_W-1:0]  rdata_q, rdata_d;
    logic               load_seen_q, load_seen_d;
`ifdef T9990_PALETTE_PREFETCH_EN
    logic               pf_valid_q, pf_valid_d;
    logic [DATA_W-1:0]  pf_data_q, pf_data_d;
`endif

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   acc_ptr;
    logic               ptr_adv;
    logic               unused_wdata;

    // Bits 6:5 of the CPU byte have no place in the 5-bit colour format.
    assign unused_wdata = ^P1_WDATA[6:5];

    // A load in the same cycle as an access is applied first and used by it.
    assign acc_ptr = PLTP_WE ? PLTP_WDATA : ptr;

    function automatic logic [DATA_W-1:0] pack_wdata(input logic ys, input logic [4:0] c,
                                                     input logic [SEL_W-1:0] sel);
        return (sel == PLTP_R) ? {ys, c} : {1'b0, c};
    endfunction

    function automatic logic [BYTE_W-1:0] unpack_rdata(input logic [DATA_W-1:0] d,
                                                       input logic [SEL_W-1:0] sel);
        return (sel == PLTP_R) ? {d[5], 2'b00, d[4:0]} : {3'b000, d[4:0]};
    endfunction

    t9990_palette_ptr u_ptr (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .load      (PLTP_WE),
        .load_data (PLTP_WDATA),
        .adv       (ptr_adv),
        .ptr       (ptr),
        .PLTP_OUT  (PLTP_OUT)
    );

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            w_strobe_q  <= 1'b0;
            w_addr_q    <= '0;
            w_ptr_q     <= '0;
            w_data_q    <= '0;
            r_strobe_q  <= 1'b0;
            r_addr_q    <= '0;
            r_ptr_q     <= '0;
            rdata_q     <= '0;
            load_seen_q <= 1'b0;
`ifdef T9990_PALETTE_PREFETCH_EN
            pf_valid_q  <= 1'b0;
            pf_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            w_strobe_q  <= w_strobe_d;
            w_addr_q    <= w_addr_d;
            w_ptr_q     <= w_ptr_d;
            w_data_q    <= w_data_d;
            r_strobe_q  <= r_strobe_d;
            r_addr_q    <= r_addr_d;
            r_ptr_q     <= r_ptr_d;
            rdata_q     <= rdata_d;
            load_seen_q <= load_seen_d;
`ifdef T9990_PALETTE_PREFETCH_EN
            pf_valid_q  <= pf_valid_d;
            pf_data_q   <= pf_data_d;
`endif
        end
    end

    // Next-state, transaction launch/completion and pointer advance request.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        w_strobe_d  = w_strobe_q;
        w_addr_d    = w_addr_q;
        w_ptr_d     = w_ptr_q;
        w_data_d    = w_data_q;
        r_strobe_d  = r_strobe_q;
        r_addr_d    = r_addr_q;
        r_ptr_d     = r_ptr_q;
        rdata_d     = rdata_q;
        load_seen_d = load_seen_q;
        ptr_adv     = 1'b0;
`ifdef T9990_PALETTE_PREFETCH_EN
        pf_valid_d  = pf_valid_q;
        pf_data_d   = pf_data_q;
`endif

        case (state_q)
            IDLE: begin
                load_seen_d = 1'b0;
                if (P1_WR) begin
                    w_addr_d   = acc_ptr[PTR_W-1:SEL_W];
                    w_ptr_d    = acc_ptr[SEL_W-1:0];
                    w_data_d   = pack_wdata(P1_WDATA[7], P1_WDATA[4:0], acc_ptr[SEL_W-1:0]);
                    w_strobe_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = WR_REQ;
`ifdef T9990_PALETTE_PREFETCH_EN
                    pf_valid_d = 1'b0;
                end else if (P1_RD && pf_valid_q && !PLTP_WE) begin
                    rdata_d    = unpack_rdata(pf_data_q, ptr[SEL_W-1:0]);
                    pf_valid_d = 1'b0;
                    ptr_adv    = !AIH;
`endif
                end else if (P1_RD) begin
                    r_addr_d   = acc_ptr[PTR_W-1:SEL_W];
                    r_ptr_d    = acc_ptr[SEL_W-1:0];
                    r_strobe_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = RD_REQ;
`ifdef T9990_PALETTE_PREFETCH_EN
                end else if (!pf_valid_q && !PLTP_WE) begin
                    r_addr_d   = ptr[PTR_W-1:SEL_W];
                    r_ptr_d    = ptr[SEL_W-1:0];
                    r_strobe_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = PF_REQ;
`endif
                end
            end
            WR_REQ: begin
                if (PLTP_WE) begin
                    load_seen_d = 1'b1;
                end
                if (W_ACK) begin
                    w_strobe_d = 1'b0;
                    busy_d     = 1'b0;
                    ptr_adv    = !load_seen_q;
                    state_d    = IDLE;
                end
            end
            RD_REQ: begin
                if (PLTP_WE) begin
                    load_seen_d = 1'b1;
                end
                if (R_ACK) begin
                    rdata_d    = unpack_rdata(R_DATA, r_ptr_q);
                    r_strobe_d = 1'b0;
                    busy_d     = 1'b0;
                    ptr_adv    = !load_seen_q && !AIH;
                    state_d    = IDLE;
                end
            end
`ifdef T9990_PALETTE_PREFETCH_EN
            PF_REQ: begin
                if (PLTP_WE) begin
                    load_seen_d = 1'b1;
                end
                if (R_ACK) begin
                    pf_data_d  = R_DATA;
                    pf_valid_d = !(load_seen_q || PLTP_WE);
                    r_strobe_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef T9990_PALETTE_PREFETCH_EN
        if (PLTP_WE) begin
            pf_valid_d = 1'b0;
        end
`endif
    end

    assign BUSY     = busy_q;
    assign W_STROBE = w_strobe_q;
    assign W_ADDR   = w_addr_q;
    assign W_PTR    = w_ptr_q;
    assign W_DATA   = w_data_q;
    assign R_STROBE = r_strobe_q;
    assign R_ADDR   = r_addr_q;
    assign R_PTR    = r_ptr_q;
    assign P1_RDATA = rdata_q;

endmodule

// File: tb/tb_t9990_palette_port.sv
// Scoreboard bench for t9990_palette_port (default build): random CPU traffic
// against a palette responder with random stalls and a pointer/palette model.
module tb_t9990_palette_port;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       P1_WR = 1'b0, P1_RD = 1'b0;
    logic [7:0] P1_WDATA = '0;
    logic [7:0] P1_RDATA;
    logic       BUSY;
    logic       PLTP_WE = 1'b0;
    logic [7:0] PLTP_WDATA = '0;
    logic [7:0] PLTP_OUT;
    logic       AIH = 1'b0;
    logic       W_STROBE;
    logic [5:0] W_ADDR;
    logic [1:0] W_PTR;
    logic [5:0] W_DATA;
    logic       W_ACK = 1'b0;
    logic       R_STROBE;
    logic [5:0] R_ADDR;
    logic [1:0] R_PTR;
    logic [5:0] R_DATA = '0;
    logic       R_ACK = 1'b0;

    t9990_palette_port dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .P1_WR(P1_WR), .P1_RD(P1_RD), .P1_WDATA(P1_WDATA), .P1_RDATA(P1_RDATA),
        .BUSY(BUSY), .PLTP_WE(PLTP_WE), .PLTP_WDATA(PLTP_WDATA), .PLTP_OUT(PLTP_OUT),
        .AIH(AIH),
        .W_STROBE(W_STROBE), .W_ADDR(W_ADDR), .W_PTR(W_PTR), .W_DATA(W_DATA), .W_ACK(W_ACK),
        .R_STROBE(R_STROBE), .R_ADDR(R_ADDR), .R_PTR(R_PTR), .R_DATA(R_DATA), .R_ACK(R_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct { int a; int p; int d; } wtx_t;

    int   errors = 0;
    int   checks = 0;
    wtx_t exp_w[$];
    int   exp_r[$];
    int   mem_m [64][3];
    int   mem_r [64][3];
    int   m_entry = 0, m_sel = 0;
    int   w_delay = 0, r_delay = 0;
    bit   dup_ack_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_ptr();
        return m_entry * 4 + m_sel;
    endfunction

    function automatic void m_advance();
        if (m_sel >= 2) begin
            m_sel   = 0;
            m_entry = (m_entry + 1) % 64;
        end else begin
            m_sel = m_sel + 1;
        end
    endfunction

    function automatic void m_load(input int v);
        m_entry = v / 4;
        m_sel   = v % 4;
    endfunction

    // Palette responder with programmable stall and an optional repeated ack.
    initial begin
        bit w_act = 0, r_act = 0, w_last = 0, r_last = 0;
        int wcnt = 0, rcnt = 0;
        forever begin
            @(posedge CLK); #1;
            w_last = W_ACK; r_last = R_ACK;
            W_ACK = 1'b0; R_ACK = 1'b0; R_DATA = 6'($urandom);
            if (W_STROBE) begin
                if (!w_act) begin w_act = 1; wcnt = w_delay; end
                if (wcnt == 0) begin
                    W_ACK = 1'b1; w_act = 0;
                    if (W_PTR != 2'd3) mem_r[int'(W_ADDR)][int'(W_PTR)] = int'(W_DATA);
                end else wcnt--;
            end else if (w_last && dup_ack_en && ($urandom % 2 == 1)) begin
                W_ACK = 1'b1;
            end
            if (R_STROBE) begin
                if (!r_act) begin r_act = 1; rcnt = r_delay; end
                if (rcnt == 0) begin
                    R_ACK = 1'b1; r_act = 0;
                    R_DATA = 6'(mem_r[int'(R_ADDR)][(R_PTR == 2'd3) ? 2 : int'(R_PTR)]);
                end else rcnt--;
            end else if (r_last && dup_ack_en && ($urandom % 2 == 1)) begin
                R_ACK = 1'b1;
            end
        end
    end

    // Monitor: compares each completed write and each read's returned byte.
    initial begin
        bit   rd_pend = 0;
        wtx_t t;
        forever begin
            @(negedge CLK);
            if (rd_pend) begin
                rd_pend = 0;
                if (exp_r.size() == 0) chk("unexpected_read", 1, 0);
                else chk("p1_rdata", int'(P1_RDATA), exp_r.pop_front());
            end
            if (RESET_n && W_STROBE && W_ACK) begin
                if (exp_w.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    t = exp_w.pop_front();
                    chk("w_addr", int'(W_ADDR), t.a);
                    chk("w_ptr", int'(W_PTR), t.p);
                    chk("w_data", int'(W_DATA), t.d);
                end
            end
            if (RESET_n && R_STROBE && R_ACK) rd_pend = 1;
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge CLK);
        while (BUSY === 1'b1 && n < 500) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 500) chk("busy_timeout", n, 0);
    endtask

    // One CPU operation: optional R#14 load, optional access, optional
    // mid-flight load or illegal extra pulse; model updated and pointer checked.
    task automatic op(input bit wr, input bit rd, input bit ld, input int ldv, input int wd,
                      input bit aih, input bit midld, input int midv, input bit viol,
                      output int busy_n);
        wtx_t t;
        int   raw, wv;
        busy_n = 0;
        @(posedge CLK); #1;
        if (ld) m_load(ldv);
        if (wr) begin
            wv = (wd % 32) + ((m_sel == 0 && wd >= 128) ? 32 : 0);
            t.a = m_entry; t.p = m_sel; t.d = wv;
            exp_w.push_back(t);
            if (m_sel != 3) mem_m[m_entry][m_sel] = wv;
        end else if (rd) begin
            raw = mem_m[m_entry][(m_sel == 3) ? 2 : m_sel];
            exp_r.push_back((raw % 32) + ((m_sel == 0 && raw >= 32) ? 128 : 0));
        end
        PLTP_WE = ld; PLTP_WDATA = 8'(ldv);
        P1_WR = wr; P1_RD = rd; P1_WDATA = 8'(wd); AIH = aih;
        @(posedge CLK); #1;
        PLTP_WE = 1'b0; P1_WR = 1'b0; P1_RD = 1'b0;
        if (wr || rd) begin
            if (midld) begin
                PLTP_WE = 1'b1; PLTP_WDATA = 8'(midv);
                @(posedge CLK); #1;
                PLTP_WE = 1'b0;
            end else if (viol) begin
                P1_WR = 1'b1; P1_RD = 1'b1; P1_WDATA = 8'($urandom);
                @(posedge CLK); #1;
                P1_WR = 1'b0; P1_RD = 1'b0;
            end
            wait_idle(busy_n);
            if (midld) m_load(midv);
            else if (wr || !aih) m_advance();
        end
        chk("pltp_out", int'(PLTP_OUT), m_ptr());
    endtask

    initial begin
        int n;
        int kind;
        for (int e = 0; e < 64; e++)
            for (int s = 0; s < 3; s++) begin
                mem_m[e][s] = int'($urandom % 64);
                mem_r[e][s] = mem_m[e][s];
            end

        repeat (2) @(negedge CLK);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_w_strobe", int'(W_STROBE), 0);
        chk("rst_r_strobe", int'(R_STROBE), 0);
        chk("rst_pltp_out", int'(PLTP_OUT), 0);
        chk("rst_p1_rdata", int'(P1_RDATA), 0);
        chk("rst_w_addr_data", int'({W_ADDR, W_PTR, W_DATA, R_ADDR, R_PTR}), 0);
        RESET_n = 1'b1;

        // Entry 2 R/G/B writes, packing of YS bit.
        op(0, 0, 1, 'h08, 0, 0, 0, 0, 0, n);
        op(1, 0, 0, 0, 'h9F, 0, 0, 0, 0, n);
        op(1, 0, 0, 0, 'h15, 0, 0, 0, 0, n);
        op(1, 0, 0, 0, 'h0A, 0, 0, 0, 0, n);
        chk("pltp_after_rgb", int'(PLTP_OUT), 'h0C);

        // Responder stall of 5 cycles.
        w_delay = 5;
        op(1, 0, 0, 0, 'h33, 0, 0, 0, 0, n);
        chk("busy_cycles_stall", n, w_delay + 1);
        w_delay = 0;

        // Entry wrap and selector 3 advance.
        op(0, 0, 1, 'hFE, 0, 0, 0, 0, 0, n);
        op(1, 0, 0, 0, 'h11, 0, 0, 0, 0, n);
        chk("pltp_wrap", int'(PLTP_OUT), 'h00);
        op(0, 0, 1, 'h07, 0, 0, 0, 0, 0, n);
        op(0, 1, 0, 0, 0, 0, 0, 0, 0, n);
        chk("pltp_sel3", int'(PLTP_OUT), 'h08);

        // Read unpacking with and without auto-increment inhibit.
        mem_m[1][0] = 'h25; mem_r[1][0] = 'h25;
        op(0, 1, 1, 'h04, 0, 1, 0, 0, 0, n);
        chk("rdata_aih", int'(P1_RDATA), 'h85);
        chk("pltp_aih", int'(PLTP_OUT), 'h04);
        op(0, 1, 1, 'h04, 0, 0, 0, 0, 0, n);
        chk("rdata_noaih", int'(P1_RDATA), 'h85);
        chk("pltp_noaih", int'(PLTP_OUT), 'h05);

        // Load during an in-flight write.
        w_delay = 3;
        op(1, 0, 0, 0, 'h2A, 0, 1, 'h40, 0, n);
        chk("pltp_midload", int'(PLTP_OUT), 'h40);

        // Randomized traffic with stalls, repeated acks and illegal pulses.
        dup_ack_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            w_delay = int'($urandom % 5);
            r_delay = int'($urandom % 5);
            kind = int'($urandom % 7);
            case (kind)
                0: op(1, 0, 0, 0, int'($urandom % 256), $urandom % 2, 0, 0, 0, n);
                1: op(0, 1, 0, 0, 0, $urandom % 2, 0, 0, 0, n);
                2: op(0, 0, 1, int'($urandom % 256), 0, 0, 0, 0, 0, n);
                3: op(1, 0, 1, int'($urandom % 256), int'($urandom % 256), 0, 0, 0, 0, n);
                4: op(1, 0, 0, 0, int'($urandom % 256), 0, 1, int'($urandom % 256), 0, n);
                5: op(0, 1, 0, 0, 0, $urandom % 2, 0, 0, 1, n);
                default: op(0, 1, 1, int'($urandom % 256), 0, $urandom % 2, 1, int'($urandom % 256), 0, n);
            endcase
        end
        dup_ack_en = 1'b0;
        repeat (3) @(negedge CLK);
        chk("exp_w_drained", exp_w.size(), 0);
        chk("exp_r_drained", exp_r.size(), 0);

        // Asynchronous reset in the middle of a stalled write.
        w_delay = 20;
        @(posedge CLK); #1;
        P1_WR = 1'b1; P1_WDATA = 8'h01;
        @(posedge CLK); #1;
        P1_WR = 1'b0;
        chk("busy_before_reset", int'(BUSY), 1);
        #2 RESET_n = 1'b0;
        #1;
        chk("reset_w_strobe", int'(W_STROBE), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_pltp_out", int'(PLTP_OUT), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
